// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the control, datapath-flag, memory and decoder signals of the
// instruction fetch unit into one port.
//   start/start_addr : launch a fetch sequence at start_addr
//   stall            : hold the fetch pointer, suppress new issues
//   z_flag           : accumulator-zero flag (1 = zero), used by JUMNZ
//   addr/instruction : instruction memory read address / read data
//   opcode/opcode_valid : registered opcode and its one-cycle strobe
//   jump_taken       : one-cycle strobe when JUMNZ redirects the pointer
//   halted/fault     : halt status and out-of-range fetch indicator
// Modports: master = environment (controller, memory, decoder side),
//           slave  = the fetch unit itself.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic       start;
    logic [7:0] start_addr;
    logic       stall;
    logic       z_flag;
    logic [7:0] addr;
    logic [7:0] instruction;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic       jump_taken;
    logic       halted;
    logic       fault;

    modport master (
        output start, start_addr, stall, z_flag, instruction,
        input  addr, opcode, opcode_valid, jump_taken, halted, fault
    );

    modport slave (
        input  start, start_addr, stall, z_flag, instruction,
        output addr, opcode, opcode_valid, jump_taken, halted, fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Byte-wide instruction fetch sequencer. Issues a read address, captures the
// returned byte one cycle later, and either hands it to the decoder, halts on
// OP_END, or resolves a two-byte JUMNZ (target byte follows the opcode).
// Ports:
//   clock : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : instr_fetch_unit_if.slave (start, start_addr, stall, z_flag,
//           addr, instruction, opcode, opcode_valid, jump_taken, halted, fault)
// Parameters: OP_END (halt opcode), OP_JUMNZ (conditional jump opcode).
// Optional feature: define IFETCH_BOUNDS_EN to fault on any fetch from
// pc >= 128; otherwise fault is tied low and pc wraps modulo 256.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [7:0] OP_END   = 8'd38,
    parameter logic [7:0] OP_JUMNZ = 8'd40
) (
    input logic           clock,
    input logic           reset,
    instr_fetch_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ISSUE, CAPTURE, ISSUE_T, CAPTURE_T, HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] opcode_q, opcode_d;
    logic       opcode_valid_q, opcode_valid_d;
    logic       jump_taken_q, jump_taken_d;
    logic       halted_q, halted_d;
    logic       fault_q, fault_d;
    logic       entering_issue;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        addr_d         = addr_q;
        opcode_d       = opcode_q;
        opcode_valid_d = 1'b0;
        jump_taken_d   = 1'b0;
        halted_d       = halted_q;
        fault_d        = fault_q;

        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    pc_d     = bus.start_addr;
                    halted_d = 1'b0;
                    fault_d  = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE:   if (!bus.stall) state_d = CAPTURE;
            ISSUE_T: if (!bus.stall) state_d = CAPTURE_T;
            CAPTURE: begin
                if (bus.instruction == OP_END) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (bus.instruction == OP_JUMNZ) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = ISSUE_T;
                end else begin
                    opcode_d       = bus.instruction;
                    opcode_valid_d = 1'b1;
                    pc_d           = pc_q + 8'd1;
                    state_d        = ISSUE;
                end
            end
            CAPTURE_T: begin
                if (!bus.z_flag) begin
                    pc_d         = bus.instruction;
                    jump_taken_d = 1'b1;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                state_d = ISSUE;
            end
            default: state_d = IDLE;
        endcase

        // addr is a registered copy of pc loaded on entry to an issue state,
        // so the memory samples the new address at the end of the issue cycle
        // and its data is valid during the following capture cycle.
        entering_issue = (state_d == ISSUE || state_d == ISSUE_T) && (state_d != state_q);
        if (entering_issue) begin
`ifdef IFETCH_BOUNDS_EN
            // Illegal address: never put it on the bus, halt with fault.
            if (pc_d[7]) begin
                state_d  = HALT;
                halted_d = 1'b1;
                fault_d  = 1'b1;
            end else begin
                addr_d = pc_d;
            end
`else
            addr_d  = pc_d;
            fault_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            pc_q           <= 8'd0;
            addr_q         <= 8'd0;
            opcode_q       <= 8'd0;
            opcode_valid_q <= 1'b0;
            jump_taken_q   <= 1'b0;
            halted_q       <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            addr_q         <= addr_d;
            opcode_q       <= opcode_d;
            opcode_valid_q <= opcode_valid_d;
            jump_taken_q   <= jump_taken_d;
            halted_q       <= halted_d;
            fault_q        <= fault_d;
        end
    end

    assign bus.addr         = addr_q;
    assign bus.opcode       = opcode_q;
    assign bus.opcode_valid = opcode_valid_q;
    assign bus.jump_taken   = jump_taken_q;
    assign bus.halted       = halted_q;
    assign bus.fault        = fault_q;
endmodule
